input_debouncer: RTL and testbench



---
 rtl/input_debouncer_pkg.sv | 15 +
 rtl/input_debouncer_bit.sv | 58 +++++
 rtl/input_debouncer.sv | 68 ++++++
 tb/tb_input_debouncer.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/input_debouncer_pkg.sv
// Shared constants and helpers for the input debouncer.
// Common debounce periods and the counter widths that cover them.
package input_debouncer_pkg;

    localparam int DEBOUNCE_1MS_50MHZ      = 50000;
    localparam int DEBOUNCE_10MS_50MHZ     = 500000;
    localparam int COUNT_BITS_1MS_50MHZ    = 16;
    localparam int COUNT_BITS_10MS_50MHZ   = 19;

    // Terminal counter value; 0 and 1 cycles both collapse to a single-edge debounce.
    function automatic int last_count(input int cycles);
        return (cycles <= 1) ? 0 : cycles - 1;
    endfunction

endpackage

// File: rtl/input_debouncer_bit.sv
// One debounced bit: run-length counter, registered level, edge pulses and a
// sticky event flag with write-one-to-clear.
module input_debouncer_bit
    import input_debouncer_pkg::*;
#(
    parameter int   debounce_cycles = 50000,
    parameter int   count_bits      = 16,
    parameter logic reset_level     = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic in,
    input  logic clear,
    output logic out,
    output logic rise,
    output logic fall,
    output logic event_flag
);

    localparam logic [count_bits-1:0] last = count_bits'(last_count(debounce_cycles));

    logic [count_bits-1:0] count;
    logic                  differ;
    logic                  change;

    assign differ = (in != out);
    assign change = differ && (count == last);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count      <= '0;
            out        <= reset_level;
            rise       <= 1'b0;
            fall       <= 1'b0;
            event_flag <= 1'b0;
        end else begin
            rise <= 1'b0;
            fall <= 1'b0;
            if (!differ) begin
                count <= '0;
            end else if (change) begin
                out   <= in;
                count <= '0;
                rise  <= in;
                fall  <= ~in;
            end else begin
                count <= count + 1'b1;
            end
            // A change on the same edge as a clear keeps the flag set.
            if (change) begin
                event_flag <= 1'b1;
            end else if (clear) begin
                event_flag <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/input_debouncer.sv
// Multi-bit debouncer top: parameter checks, optional input synchronizer
// (INPUT_DEBOUNCER_SYNC_EN) and one input_debouncer_bit per input bit.
module input_debouncer
    import input_debouncer_pkg::*;
#(
    parameter  int   width           = 1,
    localparam int   msb             = width - 1,
    parameter  int   debounce_cycles = DEBOUNCE_1MS_50MHZ,
    parameter  int   count_bits      = COUNT_BITS_1MS_50MHZ,
    parameter  logic reset_level     = 1'b0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [msb:0] in,
    input  logic [msb:0] event_clear,
    output logic [msb:0] out,
    output logic [msb:0] rise,
    output logic [msb:0] fall,
    output logic [msb:0] event_flag
);

    if (width < 1) begin : g_bad_width
        $error("input_debouncer: width must be at least 1");
    end
    if ((64'd1 << count_bits) < 64'(debounce_cycles)) begin : g_bad_count_bits
        $error("input_debouncer: count_bits too small for debounce_cycles");
    end

    logic [msb:0] sampled;

`ifdef INPUT_DEBOUNCER_SYNC_EN
    logic [msb:0] sync_a;
    logic [msb:0] sync_b;

    // Half-cycle first stage keeps the added latency to exactly one cycle.
    always_ff @(negedge clk or posedge reset) begin
        if (reset) sync_a <= {width{reset_level}};
        else       sync_a <= in;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) sync_b <= {width{reset_level}};
        else       sync_b <= sync_a;
    end

    assign sampled = sync_b;
`else
    assign sampled = in;
`endif

    for (genvar i = 0; i < width; i++) begin : g_bit
        input_debouncer_bit #(
            .debounce_cycles(debounce_cycles),
            .count_bits     (count_bits),
            .reset_level    (reset_level)
        ) u_bit (
            .clk       (clk),
            .reset     (reset),
            .in        (sampled[i]),
            .clear     (event_clear[i]),
            .out       (out[i]),
            .rise      (rise[i]),
            .fall      (fall[i]),
            .event_flag(event_flag[i])
        );
    end

endmodule

// File: tb/tb_input_debouncer.sv
// Bench for input_debouncer: directed scenarios plus random levels/clears/resets,
// checked against a sliding-window reference model.
module tb_input_debouncer;

    localparam int W = 2;
    localparam int D = 4;
`ifdef INPUT_DEBOUNCER_SYNC_EN
    localparam int SYNC = 1;
`else
    localparam int SYNC = 0;
`endif
    localparam int LAT = D + SYNC;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [W-1:0] in = '0;
    logic [W-1:0] event_clear = '0;
    logic [W-1:0] out, rise, fall, event_flag;

    int checks = 0;
    int errors = 0;

    input_debouncer #(
        .width(W), .debounce_cycles(D), .count_bits(3), .reset_level(1'b0)
    ) dut (
        .clk(clk), .reset(reset), .in(in), .event_clear(event_clear),
        .out(out), .rise(rise), .fall(fall), .event_flag(event_flag)
    );

    always #5 clk = ~clk;

    // Reference model: a bit flips when the last D effective samples since the
    // previous flip (or reset) all disagree with its current level.
    logic [W-1:0] samp_q[$];
    int           since[W];
    logic [W-1:0] pipe;
    logic [W-1:0] exp_out, exp_rise, exp_fall, exp_ev;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        samp_q.delete();
        for (int b = 0; b < W; b++) since[b] = 0;
        pipe = '0; exp_out = '0; exp_rise = '0; exp_fall = '0; exp_ev = '0;
    endtask

    task automatic model_edge(input logic [W-1:0] iv, input logic [W-1:0] cv);
        logic [W-1:0] eff;
        logic         all_diff;
        eff = (SYNC != 0) ? pipe : iv;
        pipe = iv;
        samp_q.push_back(eff);
        if (samp_q.size() > D) void'(samp_q.pop_front());
        exp_rise = '0;
        exp_fall = '0;
        for (int b = 0; b < W; b++) begin
            since[b]++;
            all_diff = (since[b] >= D);
            if (all_diff)
                for (int k = 0; k < D; k++)
                    if (samp_q[samp_q.size() - 1 - k][b] == exp_out[b]) all_diff = 1'b0;
            if (all_diff) begin
                exp_out[b]  = eff[b];
                exp_rise[b] = eff[b];
                exp_fall[b] = ~eff[b];
                exp_ev[b]   = 1'b1;
                since[b]    = 0;
            end else if (cv[b]) begin
                exp_ev[b] = 1'b0;
            end
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, "_out"},   32'(out),        32'(exp_out));
        check({tag, "_rise"},  32'(rise),       32'(exp_rise));
        check({tag, "_fall"},  32'(fall),       32'(exp_fall));
        check({tag, "_event"}, 32'(event_flag), 32'(exp_ev));
    endtask

    // Called at posedge+1: drive, wait one edge, update model, check at posedge+1.
    task automatic step(input logic [W-1:0] iv, input logic [W-1:0] cv, input string tag);
        in = iv;
        event_clear = cv;
        @(posedge clk);
        model_edge(iv, cv);
        #1;
        compare_all(tag);
    endtask

    task automatic do_reset(input logic [W-1:0] iv);
        in = iv;
        event_clear = '0;
        reset = 1'b1;
        model_reset();
        #1;
        compare_all("reset_async");
        repeat (2) @(posedge clk);
        #1;
        compare_all("reset_hold");
        reset = 1'b0;
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        compare_all("por");
        reset = 1'b0;
        for (int i = 0; i < 3; i++) step(2'b00, 2'b00, "idle");

        // Rise on bit 0 after exactly LAT edges.
        for (int i = 0; i < LAT - 1; i++) step(2'b01, 2'b00, "rise_wait");
        check("rise_early_out", 32'(out), 32'h0);
        step(2'b01, 2'b00, "rise_edge");
        check("rise_out", 32'(out), 32'h1);
        check("rise_pulse", 32'(rise), 32'h1);
        step(2'b01, 2'b00, "rise_after");
        check("rise_pulse_gone", 32'(rise), 32'h0);
        check("rise_event", 32'(event_flag), 32'h1);

        // Glitch shorter than the debounce window.
        for (int i = 0; i < D - 1; i++) step(2'b00, 2'b00, "glitch");
        step(2'b01, 2'b00, "glitch_end");
        for (int i = 0; i < LAT; i++) step(2'b01, 2'b00, "glitch_settle");
        check("glitch_out", 32'(out), 32'h1);
        check("glitch_fall", 32'(fall), 32'h0);

        // Clear, then clear colliding with a fall.
        step(2'b01, 2'b01, "clear");
        check("clear_event", 32'(event_flag), 32'h0);
        for (int i = 0; i < LAT - 1; i++) step(2'b00, 2'b00, "fall_wait");
        step(2'b00, 2'b01, "fall_clear");
        check("fall_clear_fall", 32'(fall), 32'h1);
        check("fall_clear_event", 32'(event_flag), 32'h1);

        // Reset in the middle of a count on bit 1.
        step(2'b10, 2'b00, "midcount");
        step(2'b10, 2'b00, "midcount");
        do_reset(2'b10);
        check("reset_out", 32'(out), 32'h0);
        for (int i = 0; i < LAT - 1; i++) step(2'b10, 2'b00, "post_reset_wait");
        check("post_reset_early", 32'(out), 32'h0);
        step(2'b10, 2'b00, "post_reset_edge");
        check("post_reset_out", 32'(out), 32'h2);
        check("post_reset_rise", 32'(rise), 32'h2);

        // Random levels with bursty toggles, random clears and occasional resets.
        begin
            logic [W-1:0] lvl;
            logic [W-1:0] clr;
            lvl = 2'b10;
            for (int n = 0; n < 600; n++) begin
                for (int b = 0; b < W; b++)
                    if ($urandom_range(0, 5) == 0) lvl[b] = ~lvl[b];
                clr = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 3)) : '0;
                if ($urandom_range(0, 199) == 0) do_reset(lvl);
                else step(lvl, clr, "rand");
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
